output_buffer: RTL and testbench
================================

Name: output_buffer

Overview:
- Receiving end of the accumulator's result-write interface.
- Captures each reduced 32-bit result the accumulator presents on its (data, buffer address) outputs into an addressed entry. Address 0 means "no write".
- Serves results to the host side in two ways:
  - a random-access read port with one-cycle latency;
  - a valid/ready drain stream that emits every occupied entry in address order and frees it.

Parameters:
- DATA_W, 32, result width; matches the accumulator output width.
- ADDR_W, 4, buffer address width. Entries are 1..2**ADDR_W-1; address 0 is the null address and never stores.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_addr  in  ADDR_W  write address from the accumulator; 0 = no write this cycle.
- wr_data  in  DATA_W  write data from the accumulator.
- rd_req  in  1  random read request.
- rd_addr  in  ADDR_W  random read address.
- rd_valid  out  1  read response strobe, one cycle after rd_req.
- rd_hit  out  1  the addressed entry held valid data.
- rd_data  out  DATA_W  read data; 0 when rd_hit=0.
- drain_start  in  1  begin a drain pass; ignored while drain_busy=1.
- drain_valid  out  1  drain beat present.
- drain_ready  in  1  consumer accepts the drain beat.
- drain_addr  out  ADDR_W  address of the current drain beat.
- drain_data  out  DATA_W  data of the current drain beat.
- drain_busy  out  1  drain pass in progress (state != IDLE).
- drain_done  out  1  one-cycle pulse at the end of a drain pass.
- occupancy  out  ADDR_W  number of valid entries, 0..2**ADDR_W-1.

Behaviour:
- Reset
  - All valid bits cleared; FSM to IDLE; pointer reset to 1.
  - All outputs 0.
  - Data storage is not reset; invalid entries always read as 0.
- Write
  - Occurs when wr_addr != 0: mem[wr_addr] <= wr_data and valid[wr_addr] <= 1 on the same edge.
  - Overwriting a valid entry is legal; last write wins.
  - Writes are accepted in every state.
- Read
  - rd_req sampled at edge T → rd_valid=1 for the cycle after T.
  - rd_hit and rd_data reflect pre-edge contents (read-before-write on an address collision).
  - rd_addr=0 → rd_hit=0, rd_data=0.
  - Reads do not clear entries.
- Occupancy: registered popcount of the valid bits, updated on the same edge as the valid bits.
- Drain FSM states are IDLE, SCAN, PRESENT, DONE. The pointer ptr is ADDR_W bits wide.
  - IDLE
    - drain_start → SCAN with ptr=1.
  - SCAN (one entry per cycle)
    - valid[ptr]=1 → PRESENT, latching drain_addr=ptr and drain_data=mem[ptr].
    - Else if ptr=max → DONE.
    - Else ptr++.
  - PRESENT
    - drain_valid=1.
    - drain_addr and drain_data are held stable until drain_valid && drain_ready.
    - On that handshake, valid[ptr] is cleared; then ptr=max → DONE, else ptr++ and → SCAN.
  - DONE
    - drain_done=1 for one cycle, then → IDLE.
- Drain latency
  - drain_start at edge T → SCAN during cycle T+1.
  - Entry 1 valid → drain_valid during cycle T+2.
  - Fully empty buffer → drain_done during cycle T+16 (ADDR_W=4).
- Collision rules
  - A write to ptr on the same edge as the drain handshake wins: the entry stays valid with the new data and is not re-sent in this pass.
  - Writes to addresses below ptr during a pass are kept for the next pass.
  - Writes to addresses above ptr are drained in this pass.
- drain_start while drain_busy=1 is ignored.
- rst asserted mid-drain aborts the pass with no drain_done pulse; all entries are lost.

Decomposition:
- Shared header/package output_buffer_pkg holds:
  - DATA_W and ADDR_W defaults, shared with the accumulator;
  - NULL_ADDR = 0;
  - drain FSM state encodings (IDLE=0, SCAN=1, PRESENT=2, DONE=3).
- One sub-module is natural: output_buffer_drain_fsm.
  - Inputs: valid vector, drain_start, drain_ready.
  - Outputs: ptr, clear strobe, FSM outputs.
- Storage, write logic, read port and popcount stay in the top module.

Test Plan:
- Reset then idle → all outputs 0, occupancy=0; rd_req at address 5 → rd_valid=1, rd_hit=0, rd_data=0.
- Writes (addr 3, 0xDEADBEEF), then (addr 0, 0x1234), then read address 3 → occupancy=1, rd_hit=1, rd_data=0xDEADBEEF; the address-0 write is not stored.
- Fill addresses 2, 7 and 15; drain with drain_ready=1 → beats (2), (7), (15) in order; drain_done pulses once; occupancy goes 3→0.
- Drain while drain_ready is held low for 4 cycles on the address-7 beat → drain_addr=7 and drain_data are held stable; one beat per handshake; no duplicates.
- Write address 2 during PRESENT at address 7 → address 2 not drained this pass, occupancy=1 after the pass; a second pass emits address 2.
- Empty buffer drain_start → drain_done 16 cycles later, drain_valid never asserted; rst during PRESENT → IDLE, occupancy=0, no drain_done.

Source files
------------

// File: rtl/output_buffer_pkg.sv
// output_buffer_pkg: shared widths, null address and drain FSM state encodings
package output_buffer_pkg;
   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 4;
   localparam int NULL_ADDR = 0;
   typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, PRESENT = 2'd2, DONE = 2'd3} drain_state_t;
endpackage

// File: rtl/output_buffer_drain_fsm.sv
// output_buffer_drain_fsm: walks entries 1..max in order, presenting each valid one as a stream beat
module output_buffer_drain_fsm #(
   parameter int DATA_W = output_buffer_pkg::DATA_W,
   parameter int ADDR_W = output_buffer_pkg::ADDR_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [2**ADDR_W-1:0] i_valid,
   input  logic [DATA_W-1:0]    i_ptr_data,
   input  logic                 i_start,
   input  logic                 i_ready,
   output logic [ADDR_W-1:0]    o_ptr,
   output logic                 o_clr,
   output logic                 o_valid,
   output logic [ADDR_W-1:0]    o_addr,
   output logic [DATA_W-1:0]    o_data,
   output logic                 o_busy,
   output logic                 o_done
);
   import output_buffer_pkg::*;
   localparam logic [ADDR_W-1:0] PTR_MAX = '1;
   drain_state_t      r_state;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic              r_valid;
   logic              r_busy;
   logic              r_done;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_ptr   <= ADDR_W'(1);
         r_addr  <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: if (i_start) begin
               r_state <= SCAN;
               r_ptr   <= ADDR_W'(1);
               r_busy  <= 1'b1;
            end
            SCAN: if (i_valid[r_ptr]) begin
               r_state <= PRESENT;
               r_addr  <= r_ptr;
               r_data  <= i_ptr_data;
               r_valid <= 1'b1;
            end else if (r_ptr == PTR_MAX) begin
               r_state <= DONE;
               r_done  <= 1'b1;
            end else
               r_ptr <= r_ptr + 1'b1;
            PRESENT: if (i_ready) begin
               r_valid <= 1'b0;
               r_state <= (r_ptr == PTR_MAX) ? DONE : SCAN;
               r_done  <= r_ptr == PTR_MAX;
               r_ptr   <= (r_ptr == PTR_MAX) ? r_ptr : r_ptr + 1'b1;
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end
   assign o_ptr   = r_ptr;
   assign o_clr   = (r_state == PRESENT) && i_ready;
   assign o_valid = r_valid;
   assign o_addr  = r_addr;
   assign o_data  = r_data;
   assign o_busy  = r_busy;
   assign o_done  = r_done;
endmodule

// File: rtl/output_buffer.sv
// output_buffer: addressed result store with a 1-cycle random read port and an in-order drain stream
module output_buffer #(
   parameter int DATA_W = output_buffer_pkg::DATA_W,
   parameter int ADDR_W = output_buffer_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_valid,
   output logic              rd_hit,
   output logic [DATA_W-1:0] rd_data,
   input  logic              drain_start,
   output logic              drain_valid,
   input  logic              drain_ready,
   output logic [ADDR_W-1:0] drain_addr,
   output logic [DATA_W-1:0] drain_data,
   output logic              drain_busy,
   output logic              drain_done,
   output logic [ADDR_W-1:0] occupancy
);
   import output_buffer_pkg::*;
   localparam int N = 2**ADDR_W;
   logic [DATA_W-1:0] r_mem [N];
   logic [N-1:0]      r_valid;
   logic [N-1:0]      w_set;
   logic [N-1:0]      w_clr;
   logic [N-1:0]      w_valid_nxt;
   logic [ADDR_W-1:0] r_occ;
   logic [ADDR_W-1:0] w_ptr;
   logic              w_clr_stb;
   logic              w_wr;
   logic              r_rd_valid;
   logic              r_rd_hit;
   logic [DATA_W-1:0] r_rd_data;
   assign w_wr = wr_addr != ADDR_W'(NULL_ADDR);
   // set after clear: a write landing on the drain handshake keeps the entry
   always_comb begin
      w_set          = '0;
      w_clr          = '0;
      w_set[wr_addr] = w_wr;
      w_clr[w_ptr]   = w_clr_stb;
      w_valid_nxt    = (r_valid & ~w_clr) | w_set;
   end
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[wr_addr] <= wr_data;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid    <= '0;
         r_occ      <= '0;
         r_rd_valid <= 1'b0;
         r_rd_hit   <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_valid    <= w_valid_nxt;
         r_occ      <= ADDR_W'($countones(w_valid_nxt));
         r_rd_valid <= rd_req;
         r_rd_hit   <= rd_req && r_valid[rd_addr];
         r_rd_data  <= (rd_req && r_valid[rd_addr]) ? r_mem[rd_addr] : '0;
      end
   end
   output_buffer_drain_fsm #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_drain (
      .clk        (clk),
      .rst        (rst),
      .i_valid    (r_valid),
      .i_ptr_data (r_mem[w_ptr]),
      .i_start    (drain_start),
      .i_ready    (drain_ready),
      .o_ptr      (w_ptr),
      .o_clr      (w_clr_stb),
      .o_valid    (drain_valid),
      .o_addr     (drain_addr),
      .o_data     (drain_data),
      .o_busy     (drain_busy),
      .o_done     (drain_done)
   );
   assign rd_valid  = r_rd_valid;
   assign rd_hit    = r_rd_hit;
   assign rd_data   = r_rd_data;
   assign occupancy = r_occ;
endmodule

// File: tb/tb_output_buffer.sv
// tb_output_buffer: directed plan items plus random traffic against a set-of-entries reference model
module tb_output_buffer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic        rd_req = 1'b0;
   logic [3:0]  rd_addr = '0;
   logic        drain_start = 1'b0;
   logic        drain_ready = 1'b0;
   logic        rd_valid, rd_hit, drain_valid, drain_busy, drain_done;
   logic [31:0] rd_data, drain_data;
   logic [3:0]  drain_addr, occupancy;
   output_buffer dut (
      .clk(clk), .rst(rst), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_hit(rd_hit), .rd_data(rd_data),
      .drain_start(drain_start), .drain_valid(drain_valid), .drain_ready(drain_ready),
      .drain_addr(drain_addr), .drain_data(drain_data), .drain_busy(drain_busy),
      .drain_done(drain_done), .occupancy(occupancy)
   );
   always #5 clk = ~clk;
   int          n_chk, n_err;
   bit          m_valid [16];
   logic [31:0] m_mem [16];
   int          pos, pres_a, pass_len, n_done, n_dv;
   bit          pres, in_pass, pass_end;
   logic [31:0] pres_d;
   int          beats [$];
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask
   function automatic int next_above(int p);
      for (int a = p + 1; a < 16; a++) if (m_valid[a]) return a;
      return 0;
   endfunction
   function automatic int m_occ();
      int c = 0;
      for (int a = 0; a < 16; a++) c += int'(m_valid[a]);
      return c;
   endfunction
   function automatic logic [63:0] beat_code();
      logic [63:0] c = '0;
      foreach (beats[i]) c = (c << 4) | 64'(beats[i]);
      return c;
   endfunction
   task automatic cyc(input logic [3:0] wa, input logic [31:0] wd, input logic rq,
                      input logic [3:0] ra, input logic ds, input logic dr);
      bit          hs, eh;
      logic [31:0] ed;
      int          ca;
      @(negedge clk);
      wr_addr = wa; wr_data = wd; rd_req = rq; rd_addr = ra; drain_start = ds; drain_ready = dr;
      eh = rq && m_valid[ra];
      ed = eh ? m_mem[ra] : 32'h0;
      hs = drain_valid && dr;
      ca = 0;
      if (drain_valid) begin
         n_dv++;
         if (!pres) begin
            pres   = 1'b1;
            pres_a = next_above(pos);
            pres_d = m_mem[pres_a];
         end
         chk("drain_addr", drain_addr, pres_a);
         chk("drain_data", drain_data, pres_d);
      end
      if (hs) begin
         beats.push_back(pres_a);
         ca   = pres_a;
         pos  = pres_a;
         pres = 1'b0;
      end
      @(posedge clk);
      if (hs) m_valid[ca] = 1'b0;
      if (wa != 0) begin
         m_valid[wa] = 1'b1;
         m_mem[wa]   = wd;
      end
      if (pass_end) begin
         in_pass  = 1'b0;
         pass_end = 1'b0;
      end else if (ds && !in_pass) begin
         in_pass  = 1'b1;
         pos      = 0;
         pass_len = 0;
      end
      if (in_pass) pass_len++;
      #1;
      chk("rd_valid", rd_valid, rq);
      if (rq) begin
         chk("rd_hit", rd_hit, eh);
         chk("rd_data", rd_data, ed);
      end
      chk("occupancy", occupancy, m_occ());
      chk("drain_busy", drain_busy, in_pass);
      chk("drain_valid_idle", drain_valid && !in_pass, 0);
      if (drain_done) begin
         n_done++;
         chk("done_entries_left", next_above(pos), 0);
         pass_end = 1'b1;
      end
      if (in_pass) chk("pass_budget", pass_len > 200, 0);
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; wr_addr = '0; rd_req = 1'b0; drain_start = 1'b0; drain_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int a = 0; a < 16; a++) m_valid[a] = 1'b0;
      in_pass = 0; pass_end = 0; pres = 0; pos = 0;
      beats.delete();
      chk("rst_occupancy", occupancy, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_hit", rd_hit, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_drain_valid", drain_valid, 0);
      chk("rst_drain_addr", drain_addr, 0);
      chk("rst_drain_data", drain_data, 0);
      chk("rst_drain_busy", drain_busy, 0);
      chk("rst_drain_done", drain_done, 0);
      @(negedge clk);
      rst = 1'b0;
   endtask
   task automatic wait_dv();
      int n = 0;
      while (!drain_valid && n < 40) begin
         cyc(0, 0, 0, 0, 0, 0);
         n++;
      end
      chk("dv_seen", drain_valid, 1);
   endtask
   task automatic wait_done(input logic dr);
      int n = 0;
      while (!drain_done && n < 60) begin
         cyc(0, 0, 0, 0, 0, dr);
         n++;
      end
      chk("done_seen", drain_done, 1);
      cyc(0, 0, 0, 0, 0, 0);
   endtask
   initial begin
      int          d, n;
      logic [3:0]  wa;
      logic [31:0] d1, d2;
      for (int a = 0; a < 16; a++) m_mem[a] = '0;
      do_reset();
      cyc(0, 0, 1, 5, 0, 0);
      cyc(3, 32'hDEADBEEF, 0, 0, 0, 0);
      cyc(0, 32'h1234, 0, 0, 0, 0);
      cyc(0, 0, 1, 3, 0, 0);
      chk("occ_one", occupancy, 1);
      chk("rd3_hit", rd_hit, 1);
      chk("rd3_data", rd_data, 32'hDEADBEEF);
      // in-order drain with consumer always ready
      do_reset();
      cyc(2, $urandom, 0, 0, 0, 0);
      cyc(7, $urandom, 0, 0, 0, 0);
      cyc(15, $urandom, 0, 0, 0, 0);
      chk("occ_three", occupancy, 3);
      d = n_done;
      cyc(0, 0, 0, 0, 1, 1);
      wait_done(1);
      cyc(0, 0, 0, 0, 0, 1);
      chk("order_ready", beat_code(), 64'h27F);
      chk("done_once", n_done - d, 1);
      chk("occ_drained", occupancy, 0);
      // consumer stalls on the address-7 beat
      do_reset();
      cyc(2, $urandom, 0, 0, 0, 0);
      cyc(7, $urandom, 0, 0, 0, 0);
      cyc(15, $urandom, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      wait_dv();
      cyc(0, 0, 0, 0, 0, 1);
      wait_dv();
      chk("stall_addr", drain_addr, 7);
      repeat (4) begin
         cyc(0, 0, 0, 0, 0, 0);
         chk("hold_addr", drain_addr, 7);
         chk("hold_valid", drain_valid, 1);
      end
      cyc(0, 0, 0, 0, 0, 1);
      wait_dv();
      cyc(0, 0, 0, 0, 0, 1);
      wait_done(0);
      chk("order_stall", beat_code(), 64'h27F);
      // write below the scan pointer waits for the next pass
      do_reset();
      cyc(7, $urandom, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      wait_dv();
      cyc(2, 32'hA5A5_0002, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1);
      wait_done(0);
      chk("order_below", beat_code(), 64'h7);
      chk("occ_below", occupancy, 1);
      beats.delete();
      cyc(0, 0, 0, 0, 1, 1);
      wait_done(1);
      chk("order_second", beat_code(), 64'h2);
      // write on the handshake edge wins and is kept
      do_reset();
      d1 = $urandom;
      d2 = ~d1;
      cyc(9, d1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      wait_dv();
      cyc(9, d2, 0, 0, 0, 1);
      wait_done(0);
      chk("occ_collide", occupancy, 1);
      cyc(0, 0, 1, 9, 0, 0);
      chk("collide_data", rd_data, d2);
      cyc(0, 0, 0, 0, 1, 1);
      wait_done(1);
      chk("order_collide", beat_code(), 64'h99);
      // entry 1 reaches the stream two cycles after start
      do_reset();
      cyc(1, $urandom, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      chk("lat_t1", drain_valid, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("lat_t2", drain_valid, 1);
      cyc(0, 0, 0, 0, 0, 1);
      wait_done(1);
      // empty buffer pass
      do_reset();
      d = n_dv;
      cyc(0, 0, 0, 0, 1, 0);
      n = 0;
      while (!drain_done && n < 40) begin
         cyc(0, 0, 0, 0, 0, 0);
         n++;
      end
      chk("empty_latency", n, 15);
      chk("empty_no_beat", n_dv - d, 0);
      cyc(0, 0, 0, 0, 0, 0);
      // reset aborts a pass in PRESENT
      do_reset();
      cyc(5, $urandom, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      wait_dv();
      cyc(0, 0, 0, 0, 0, 0);
      d = n_done;
      do_reset();
      repeat (3) cyc(0, 0, 0, 0, 0, 1);
      chk("rst_abort_no_done", n_done - d, 0);
      // random traffic; writes during a pass only land below the drained point
      do_reset();
      repeat (3000) begin
         wa = '0;
         if ($urandom % 3 == 0) begin
            if (!in_pass) wa = 4'($urandom_range(15, 0));
            else if (pos > 0) wa = 4'($urandom_range(pos, 1));
         end
         cyc(wa, $urandom, ($urandom % 2) == 1, 4'($urandom), ($urandom % 16) == 0, ($urandom % 4) != 0);
      end
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
